// File: rtl/pixel_stream_checker.sv
// pixel_stream_checker
// On-chip checker for the 16-bit capture word stream headed for SD. It walks
// the frame structure (header, thumbnailed pixel ramp, Fletcher-32 checksum,
// padding), raises sticky error flags and captures the first failure so the
// result can be read back instead of halting a simulation.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 1-cycle pulse, latches cfg_*, honoured in IDLE/DONE only
//   cfg_header_words      header words (checksummed, not pixel-checked)
//   cfg_width/height      thumbnail dimensions in pixels
//   cfg_padding_words     padding words expected after the checksum
//   cfg_pixel_validate    enable pixel value checks
//   cfg_pixel_initial     expected first pixel value
//   cfg_pixel_delta       per-full-image-pixel increment
//   cfg_filter_period/keep thumbnail filter (keep = period = 1 is full image)
//   cfg_checksum_validate enable checksum compare
//   cfg_stop_on_error     halt on first error
//   din/din_valid/din_ready  word stream (little-endian on the wire)
//   eos                   end-of-stream pulse
//   busy, pass, fail      status
//   err_*                 sticky flags, saturating count, first-error capture
module pixel_stream_checker #(
  parameter int DimWidth      = 12,
  parameter int CountWidth    = 24,
  parameter int ErrCountWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CountWidth-1:0]    cfg_header_words,
  input  logic [DimWidth-1:0]      cfg_width,
  input  logic [DimWidth-1:0]      cfg_height,
  input  logic [CountWidth-1:0]    cfg_padding_words,
  input  logic                     cfg_pixel_validate,
  input  logic [15:0]              cfg_pixel_initial,
  input  logic [15:0]              cfg_pixel_delta,
  input  logic [DimWidth-1:0]      cfg_filter_period,
  input  logic [DimWidth-1:0]      cfg_filter_keep,
  input  logic                     cfg_checksum_validate,
  input  logic                     cfg_stop_on_error,
  input  logic [15:0]              din,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     eos,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic                     err_pixel,
  output logic                     err_checksum,
  output logic                     err_overrun,
  output logic                     err_underrun,
  output logic [ErrCountWidth-1:0] err_count,
  output logic [CountWidth-1:0]    err_word_idx,
  output logic [31:0]              err_expected,
  output logic [31:0]              err_got
);

  localparam int NpixWidth = 2 * DimWidth;
  localparam int EcWidth   = ErrCountWidth + 1;
  localparam logic [DimWidth-1:0]   DIM_ZERO = DimWidth'(1'b0);
  localparam logic [DimWidth-1:0]   DIM_ONE  = DimWidth'(1'b1);
  localparam logic [CountWidth-1:0] CNT_ZERO = CountWidth'(1'b0);
  localparam logic [CountWidth-1:0] CNT_ONE  = CountWidth'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HEADER, S_PIXEL, S_CK0, S_CK1, S_PAD, S_DONE
  } state_t;

  // Fletcher running sum step: (a + b) mod 65535 for a, b < 65536.
  function automatic logic [15:0] fletcher_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 17'd65535) begin
      sum = sum - 17'd65535;
    end else begin
      sum = sum;
    end
    return sum[15:0];
  endfunction

  // Product modulo 2^16.
  function automatic logic [15:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] prod;
    prod = a * b;
    return prod;
  endfunction

  state_t state_r, state_s, after_s;

  // Latched configuration
  logic [CountWidth-1:0] hdr_r, pad_r;
  logic [DimWidth-1:0]   width_r, height_r, period_r, keep_r;
  logic                  pix_validate_r, ck_validate_r, stop_on_err_r;
  logic [15:0]           initial_r, delta_r;

  // Constants derived in SETUP
  logic [15:0]           col_skip_r, row_step_r, row_skip_r;
  logic [CountWidth-1:0] total_r;

  // Frame walking state
  logic [CountWidth-1:0] word_idx_r, reg_cnt_r;
  logic [DimWidth-1:0]   col_r, row_r, col_mod_r, row_mod_r;
  logic [15:0]           cur_r, row_base_r, s1_r, s2_r, ck0_r;
  logic                  eos_seen_r, halted_r;

  // Combinational helpers
  logic                  accept_s, restart_s, in_frame_s, pix_empty_s;
  logic [15:0]           h_s, s1_n_s, s2_n_s, row_base_n_s;
  logic [DimWidth-1:0]   keep_eff_s, keep_m1_s, groups_s;
  logic [15:0]           wf_s, pk1_s;
  logic [NpixWidth-1:0]  npix_s;
  logic [CountWidth-1:0] word_cnt_after_s;
  logic                  pix_err_s, ck_err_s, ovr_err_s, und_err_s, word_err_s;
  logic                  row_end_s, region_last_s;

  assign accept_s    = din_valid & din_ready;
  assign h_s         = {din[7:0], din[15:8]};
  assign restart_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign in_frame_s  = state_r inside {S_HEADER, S_PIXEL, S_CK0, S_CK1, S_PAD};
  assign pix_empty_s = (width_r == DIM_ZERO) || (height_r == DIM_ZERO);
  assign s1_n_s      = fletcher_add(s1_r, h_s);
  assign s2_n_s      = fletcher_add(s2_r, s1_n_s);
  assign word_cnt_after_s = word_idx_r + CountWidth'(accept_s);

  // A zero keep is treated as 1 so the setup divide and the wrap compares stay defined.
  assign keep_eff_s = (keep_r == DIM_ZERO) ? DIM_ONE : keep_r;
  assign keep_m1_s  = keep_eff_s - DIM_ONE;
  assign groups_s   = width_r / keep_eff_s;
  assign wf_s       = mul16(16'(groups_s), 16'(period_r));
  assign pk1_s      = 16'(period_r) - 16'(keep_r) + 16'd1;
  assign npix_s     = NpixWidth'(width_r) * NpixWidth'(height_r);
  assign row_base_n_s = row_base_r + ((row_mod_r == keep_m1_s) ? row_skip_r : row_step_r);

  // Next-state decode plus per-word error detection.
  always_comb begin
    state_s       = state_r;
    after_s       = state_r;
    pix_err_s     = 1'b0;
    ck_err_s      = 1'b0;
    ovr_err_s     = 1'b0;
    und_err_s     = 1'b0;
    row_end_s     = 1'b0;
    region_last_s = 1'b0;
    case (state_r)
      S_IDLE: after_s = start ? S_SETUP : S_IDLE;
      S_SETUP: begin
        if (hdr_r != CNT_ZERO) after_s = S_HEADER;
        else if (!pix_empty_s) after_s = S_PIXEL;
        else after_s = S_CK0;
      end
      S_HEADER: begin
        if (accept_s && (reg_cnt_r == hdr_r - CNT_ONE)) begin
          region_last_s = 1'b1;
          after_s = pix_empty_s ? S_CK0 : S_PIXEL;
        end else begin
          after_s = S_HEADER;
        end
      end
      S_PIXEL: begin
        if (accept_s) begin
          pix_err_s = pix_validate_r && (h_s != cur_r);
          if (col_r == width_r - DIM_ONE) begin
            row_end_s = 1'b1;
            after_s = (row_r == height_r - DIM_ONE) ? S_CK0 : S_PIXEL;
          end else begin
            after_s = S_PIXEL;
          end
        end else begin
          after_s = S_PIXEL;
        end
      end
      S_CK0: after_s = accept_s ? S_CK1 : S_CK0;
      S_CK1: begin
        if (accept_s) begin
          ck_err_s = ck_validate_r && ({h_s, ck0_r} != {s2_r, s1_r});
          after_s = (pad_r != CNT_ZERO) ? S_PAD : S_DONE;
        end else begin
          after_s = S_CK1;
        end
      end
      S_PAD: begin
        if (accept_s && (reg_cnt_r == pad_r - CNT_ONE)) after_s = S_DONE;
        else after_s = S_PAD;
      end
      S_DONE: begin
        ovr_err_s = accept_s;
        after_s = start ? S_SETUP : S_DONE;
      end
      default: after_s = S_IDLE;
    endcase
    word_err_s = pix_err_s | ck_err_s | ovr_err_s;
    // The word is consumed first; eos is then judged against the post-word state.
    if (in_frame_s) begin
      if (stop_on_err_r && word_err_s) begin
        state_s = S_DONE;
      end else if (eos && (after_s != S_DONE)) begin
        und_err_s = 1'b1;
        state_s   = S_DONE;
      end else begin
        state_s = after_s;
      end
    end else begin
      state_s = after_s;
    end
  end

  // Status-side next values, all registered below.
  logic                     err_pixel_s, err_checksum_s, err_overrun_s, err_underrun_s;
  logic                     any_flag_s, eos_seen_s, halted_s, capture_s;
  logic [EcWidth-1:0]       cnt_sum_s;
  logic [ErrCountWidth-1:0] err_count_s;
  logic [31:0]              cap_exp_s, cap_got_s;
  logic [CountWidth-1:0]    cap_idx_s;

  // Flag accumulation, saturating count and first-error capture values.
  always_comb begin
    err_pixel_s    = !restart_s && (err_pixel    || pix_err_s);
    err_checksum_s = !restart_s && (err_checksum || ck_err_s);
    err_overrun_s  = !restart_s && (err_overrun  || ovr_err_s);
    err_underrun_s = !restart_s && (err_underrun || und_err_s);
    any_flag_s     = err_pixel_s || err_checksum_s || err_overrun_s || err_underrun_s;
    eos_seen_s     = !restart_s && (eos_seen_r ||
                     (eos && (after_s == S_DONE) && (word_cnt_after_s == total_r)));
    halted_s       = !restart_s && (halted_r || (stop_on_err_r && (word_err_s || und_err_s)));
    capture_s      = !restart_s && !fail && (word_err_s || und_err_s);
    cnt_sum_s      = {1'b0, err_count} + EcWidth'(word_err_s) + EcWidth'(und_err_s);
    if (restart_s) begin
      err_count_s = {ErrCountWidth{1'b0}};
    end else if (cnt_sum_s[ErrCountWidth]) begin
      err_count_s = {ErrCountWidth{1'b1}};
    end else begin
      err_count_s = cnt_sum_s[ErrCountWidth-1:0];
    end
    cap_idx_s = word_idx_r;
    if (pix_err_s) begin
      cap_exp_s = {16'd0, cur_r};
      cap_got_s = {16'd0, h_s};
    end else if (ck_err_s) begin
      cap_exp_s = {s2_r, s1_r};
      cap_got_s = {h_s, ck0_r};
    end else if (ovr_err_s) begin
      cap_exp_s = 32'(total_r);
      cap_got_s = {16'd0, h_s};
    end else begin
      // Underrun: expected vs. received word totals.
      cap_exp_s = 32'(total_r);
      cap_got_s = 32'(word_cnt_after_s);
      cap_idx_s = word_cnt_after_s;
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      din_ready <= 1'b0;  busy <= 1'b0;  pass <= 1'b0;  fail <= 1'b0;
      err_pixel <= 1'b0;  err_checksum <= 1'b0;
      err_overrun <= 1'b0; err_underrun <= 1'b0;
      err_count <= {ErrCountWidth{1'b0}};
      err_word_idx <= CNT_ZERO;
      err_expected <= 32'd0;  err_got <= 32'd0;
      eos_seen_r <= 1'b0;  halted_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      din_ready    <= (state_s inside {S_HEADER, S_PIXEL, S_CK0, S_CK1, S_PAD, S_DONE}) && !halted_s;
      busy         <= state_s inside {S_SETUP, S_HEADER, S_PIXEL, S_CK0, S_CK1, S_PAD};
      pass         <= (state_s == S_DONE) && !any_flag_s && eos_seen_s;
      fail         <= any_flag_s;
      err_pixel    <= err_pixel_s;
      err_checksum <= err_checksum_s;
      err_overrun  <= err_overrun_s;
      err_underrun <= err_underrun_s;
      err_count    <= err_count_s;
      eos_seen_r   <= eos_seen_s;
      halted_r     <= halted_s;
      if (restart_s) begin
        err_word_idx <= CNT_ZERO;
        err_expected <= 32'd0;
        err_got      <= 32'd0;
      end else if (capture_s) begin
        err_word_idx <= cap_idx_s;
        err_expected <= cap_exp_s;
        err_got      <= cap_got_s;
      end
    end
  end

  // Config latch, setup constants and the frame-walking datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_r <= CNT_ZERO;  pad_r <= CNT_ZERO;  total_r <= CNT_ZERO;
      width_r <= DIM_ZERO;  height_r <= DIM_ZERO;  period_r <= DIM_ZERO;  keep_r <= DIM_ZERO;
      pix_validate_r <= 1'b0;  ck_validate_r <= 1'b0;  stop_on_err_r <= 1'b0;
      initial_r <= 16'd0;  delta_r <= 16'd0;
      col_skip_r <= 16'd0;  row_step_r <= 16'd0;  row_skip_r <= 16'd0;
      word_idx_r <= CNT_ZERO;  reg_cnt_r <= CNT_ZERO;
      col_r <= DIM_ZERO;  row_r <= DIM_ZERO;  col_mod_r <= DIM_ZERO;  row_mod_r <= DIM_ZERO;
      cur_r <= 16'd0;  row_base_r <= 16'd0;  s1_r <= 16'd0;  s2_r <= 16'd0;  ck0_r <= 16'd0;
    end else if (restart_s) begin
      hdr_r <= cfg_header_words;  pad_r <= cfg_padding_words;
      width_r <= cfg_width;  height_r <= cfg_height;
      period_r <= cfg_filter_period;  keep_r <= cfg_filter_keep;
      pix_validate_r <= cfg_pixel_validate;  ck_validate_r <= cfg_checksum_validate;
      stop_on_err_r <= cfg_stop_on_error;
      initial_r <= cfg_pixel_initial;  delta_r <= cfg_pixel_delta;
    end else if (state_r == S_SETUP) begin
      col_skip_r <= mul16(pk1_s, delta_r);
      row_step_r <= mul16(wf_s, delta_r);
      row_skip_r <= mul16(pk1_s, mul16(wf_s, delta_r));
      total_r    <= hdr_r + CountWidth'(npix_s) + CountWidth'(2'd2) + pad_r;
      word_idx_r <= CNT_ZERO;  reg_cnt_r <= CNT_ZERO;
      col_r <= DIM_ZERO;  row_r <= DIM_ZERO;  col_mod_r <= DIM_ZERO;  row_mod_r <= DIM_ZERO;
      cur_r <= initial_r;  row_base_r <= initial_r;
      s1_r <= 16'd0;  s2_r <= 16'd0;  ck0_r <= 16'd0;
    end else if (accept_s) begin
      word_idx_r <= word_idx_r + CNT_ONE;
      case (state_r)
        S_HEADER: begin
          s1_r <= s1_n_s;
          s2_r <= s2_n_s;
          reg_cnt_r <= region_last_s ? CNT_ZERO : reg_cnt_r + CNT_ONE;
        end
        S_PIXEL: begin
          s1_r <= s1_n_s;
          s2_r <= s2_n_s;
          if (row_end_s) begin
            row_base_r <= row_base_n_s;
            cur_r      <= row_base_n_s;
            col_r      <= DIM_ZERO;
            col_mod_r  <= DIM_ZERO;
            row_r      <= row_r + DIM_ONE;
            row_mod_r  <= (row_mod_r == keep_m1_s) ? DIM_ZERO : row_mod_r + DIM_ONE;
          end else begin
            cur_r     <= cur_r + ((col_mod_r == keep_m1_s) ? col_skip_r : delta_r);
            col_r     <= col_r + DIM_ONE;
            col_mod_r <= (col_mod_r == keep_m1_s) ? DIM_ZERO : col_mod_r + DIM_ONE;
          end
        end
        S_CK0:   ck0_r <= h_s;
        S_PAD:   reg_cnt_r <= reg_cnt_r + CNT_ONE;
        default: reg_cnt_r <= reg_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_checker.sv
// Directed bench for pixel_stream_checker: full-image frame, thumbnail frame,
// pixel/checksum corruption, padding overrun/underrun, stop-on-error halt and
// asynchronous reset in mid-frame.
module tb_pixel_stream_checker;
  localparam int DW = 12;
  localparam int CW = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_header_words, cfg_padding_words;
  logic [DW-1:0] cfg_width, cfg_height, cfg_filter_period, cfg_filter_keep;
  logic          cfg_pixel_validate, cfg_checksum_validate, cfg_stop_on_error;
  logic [15:0]   cfg_pixel_initial, cfg_pixel_delta;
  logic [15:0]   din;
  logic          din_valid, din_ready, eos;
  logic          busy, pass, fail;
  logic          err_pixel, err_checksum, err_overrun, err_underrun;
  logic [EW-1:0] err_count;
  logic [CW-1:0] err_word_idx;
  logic [31:0]   err_expected, err_got;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Expected thumbnail h values (P=4, K=2, W=4, Ht=2, delta 1).
  logic [15:0] thumb_h [8] = '{16'd0, 16'd1, 16'd4, 16'd5, 16'd8, 16'd9, 16'd12, 16'd13};

  always #5 clk = ~clk;

  pixel_stream_checker #(.DimWidth(DW), .CountWidth(CW), .ErrCountWidth(EW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_header_words(cfg_header_words), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_padding_words(cfg_padding_words), .cfg_pixel_validate(cfg_pixel_validate),
    .cfg_pixel_initial(cfg_pixel_initial), .cfg_pixel_delta(cfg_pixel_delta),
    .cfg_filter_period(cfg_filter_period), .cfg_filter_keep(cfg_filter_keep),
    .cfg_checksum_validate(cfg_checksum_validate), .cfg_stop_on_error(cfg_stop_on_error),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .eos(eos),
    .busy(busy), .pass(pass), .fail(fail),
    .err_pixel(err_pixel), .err_checksum(err_checksum),
    .err_overrun(err_overrun), .err_underrun(err_underrun),
    .err_count(err_count), .err_word_idx(err_word_idx),
    .err_expected(err_expected), .err_got(err_got)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic full_cfg(input logic [CW-1:0] pd, input logic stop);
    cfg_header_words = 24'd0;   cfg_width = 12'd4;   cfg_height = 12'd2;
    cfg_padding_words = pd;     cfg_pixel_validate = 1'b1;
    cfg_pixel_initial = 16'h0100; cfg_pixel_delta = 16'd1;
    cfg_filter_period = 12'd1;  cfg_filter_keep = 12'd1;
    cfg_checksum_validate = 1'b1; cfg_stop_on_error = stop;
  endtask

  task automatic thumb_cfg();
    cfg_header_words = 24'd0;   cfg_width = 12'd4;   cfg_height = 12'd2;
    cfg_padding_words = 24'd0;  cfg_pixel_validate = 1'b1;
    cfg_pixel_initial = 16'd0;  cfg_pixel_delta = 16'd1;
    cfg_filter_period = 12'd4;  cfg_filter_keep = 12'd2;
    cfg_checksum_validate = 1'b0; cfg_stop_on_error = 1'b0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy+1"}, {31'd0, busy}, 32'd1);
    check({tag, " ready+1"}, {31'd0, din_ready}, 32'd0);
    check({tag, " cleared"}, {23'd0, fail, err_count}, 32'd0);
    tick();
    check({tag, " ready+2"}, {31'd0, din_ready}, 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic eos_pulse();
    eos = 1'b1;
    tick();
    eos = 1'b0;
  endtask

  // Full-image pixel words: on-wire byte-swap of h = 0x0100 + i.
  task automatic send_full_pixels(input int bad_idx);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] lo;
      lo = 8'(i);
      if (i == bad_idx) send(16'h0901);
      else send({lo, 8'h01});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = 16'd0; din_valid = 1'b0; eos = 1'b0;
    full_cfg(24'd0, 1'b0);
    #2;
    check("rst din_ready", {31'd0, din_ready}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst pass/fail", {30'd0, pass, fail}, 32'd0);
    check("rst flags", {28'd0, err_pixel, err_checksum, err_overrun, err_underrun}, 32'd0);
    check("rst err_count", {24'd0, err_count}, 32'd0);
    check("rst err_word_idx", {8'd0, err_word_idx}, 32'd0);
    #2 rst = 1'b0;
    tick();

    // Full-image clean frame.
    full_cfg(24'd0, 1'b0);
    do_start("full");
    send_full_pixels(-1);
    send(16'h1C08);
    send(16'h5424);
    check("full busy in DONE", {31'd0, busy}, 32'd0);
    check("full pass before eos", {31'd0, pass}, 32'd0);
    eos_pulse();
    check("full pass", {31'd0, pass}, 32'd1);
    check("full fail", {31'd0, fail}, 32'd0);
    check("full err_count", {24'd0, err_count}, 32'd0);

    // Thumbnail clean frame, restarted from DONE.
    thumb_cfg();
    do_start("thumb");
    for (int i = 0; i < 8; i++) send({thumb_h[i][7:0], thumb_h[i][15:8]});
    send(16'hDEAD);
    send(16'hBEEF);
    eos_pulse();
    check("thumb pass", {31'd0, pass}, 32'd1);

    // Thumbnail with 2 sent at index 2.
    thumb_cfg();
    do_start("thumb_err");
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        send(16'h0200);
        check("thumb err_pixel", {31'd0, err_pixel}, 32'd1);
        check("thumb err_word_idx", {8'd0, err_word_idx}, 32'd2);
        check("thumb err_expected", err_expected, 32'd4);
        check("thumb err_got", err_got, 32'd2);
      end else begin
        send({thumb_h[i][7:0], thumb_h[i][15:8]});
        if (i == 1) check("thumb no err yet", {31'd0, err_pixel}, 32'd0);
      end
    end
    send(16'h0000);
    send(16'h0000);
    eos_pulse();
    check("thumb_err pass", {31'd0, pass}, 32'd0);
    check("thumb_err fail", {31'd0, fail}, 32'd1);
    check("thumb_err count", {24'd0, err_count}, 32'd1);

    // Checksum corruption.
    full_cfg(24'd0, 1'b0);
    do_start("cksum");
    send_full_pixels(-1);
    send(16'h1C08);
    check("cksum not yet", {31'd0, err_checksum}, 32'd0);
    send(16'h5425);
    check("cksum flag", {31'd0, err_checksum}, 32'd1);
    check("cksum expected", err_expected, 32'h2454081C);
    check("cksum got", err_got, 32'h2554081C);
    check("cksum idx", {8'd0, err_word_idx}, 32'd9);
    eos_pulse();
    check("cksum pass", {31'd0, pass}, 32'd0);

    // Padding overrun: four words where three are expected.
    full_cfg(24'd3, 1'b0);
    do_start("ovr");
    send_full_pixels(-1);
    send(16'h1C08);
    send(16'h5424);
    for (int i = 0; i < 3; i++) send(16'h0000);
    check("ovr not yet", {31'd0, err_overrun}, 32'd0);
    send(16'h0000);
    check("ovr flag", {31'd0, err_overrun}, 32'd1);
    check("ovr idx", {8'd0, err_word_idx}, 32'd13);
    check("ovr count", {24'd0, err_count}, 32'd1);
    eos_pulse();
    check("ovr pass", {31'd0, pass}, 32'd0);

    // Padding underrun: two words then eos.
    full_cfg(24'd3, 1'b0);
    do_start("und");
    send_full_pixels(-1);
    send(16'h1C08);
    send(16'h5424);
    send(16'h0000);
    send(16'h0000);
    eos_pulse();
    check("und flag", {31'd0, err_underrun}, 32'd1);
    check("und fail/pass", {30'd0, fail, pass}, 32'd2);
    check("und busy", {31'd0, busy}, 32'd0);

    // Stop on error: bad pixel at index 1.
    full_cfg(24'd0, 1'b1);
    do_start("stop");
    send(16'h0001);
    send(16'h0901);
    check("stop ready drop", {31'd0, din_ready}, 32'd0);
    check("stop fail", {31'd0, fail}, 32'd1);
    check("stop count", {24'd0, err_count}, 32'd1);
    check("stop idx", {8'd0, err_word_idx}, 32'd1);
    send(16'h0201);
    check("stop no accept", {24'd0, err_count}, 32'd1);
    check("stop no overrun", {31'd0, err_overrun}, 32'd0);

    // Asynchronous reset in the middle of the pixel region.
    full_cfg(24'd0, 1'b0);
    do_start("rstmid");
    send(16'h0001);
    send(16'h0901);
    send(16'h0201);
    check("rstmid err before", {24'd0, err_count}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid ready", {31'd0, din_ready}, 32'd0);
    check("rstmid busy", {31'd0, busy}, 32'd0);
    check("rstmid status", {30'd0, pass, fail}, 32'd0);
    check("rstmid err_pixel", {31'd0, err_pixel}, 32'd0);
    check("rstmid err_count", {24'd0, err_count}, 32'd0);
    check("rstmid err_got", err_got, 32'd0);
    #1 rst = 1'b0;
    tick();
    do_start("after_rst");
    send_full_pixels(-1);
    send(16'h1C08);
    send(16'h5424);
    eos_pulse();
    check("after_rst pass", {31'd0, pass}, 32'd1);
    check("after_rst fail", {31'd0, fail}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
